core_sequencer: RTL



---
 rtl/core_seq_pkg.sv | 57 +++++
 rtl/core_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_pkg.sv
// core_seq_pkg
// Shared definitions for the core_module upstream sequencer: opcode values,
// FSM state encoding, engine mode encoding, frame sizes and opcode decode
// helpers.
package core_seq_pkg;

  // Mode opcodes carried in the first byte of every frame.
  localparam logic [7:0] OP_SINGLE = 8'h01;
  localparam logic [7:0] OP_SA3    = 8'h02;
  localparam logic [7:0] OP_SA2    = 8'h03;

  // Frame geometry: 4x4 matrix A, 3x3 matrix B, 2x2 result C.
  localparam int NUM_A = 16;
  localparam int NUM_B = 9;
  localparam int NUM_C = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_SEND   = 3'd3,
    ST_WAIT_S = 3'd4,
    ST_RUN    = 3'd5,
    ST_DRAIN  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_SA3    = 2'd1,
    MODE_SA2    = 2'd2
  } mode_t;

  // True for the three opcodes the core understands.
  function automatic logic op_legal(input logic [7:0] op);
    logic legal;
    case (op)
      OP_SINGLE: legal = 1'b1;
      OP_SA3:    legal = 1'b1;
      OP_SA2:    legal = 1'b1;
      default:   legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Opcode to engine mode; only meaningful when op_legal(op) is true.
  function automatic mode_t op_to_mode(input logic [7:0] op);
    mode_t m;
    case (op)
      OP_SINGLE: m = MODE_SINGLE;
      OP_SA3:    m = MODE_SA3;
      OP_SA2:    m = MODE_SA2;
      default:   m = MODE_SINGLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// core_sequencer
// Upstream sequencer for core_module. Receives a byte frame
// (opcode, 16 bytes of A row-major, 9 bytes of B row-major), holds the
// matrices stable on a11..a44 / b11..b33, performs the active_send/done_send
// handshake, selects exactly one engine until its done flag arrives, captures
// c11..c22 and streams them out as four bytes.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid/in_data/in_ready upstream byte stream (accept = valid & ready)
//   a11..a44, b11..b33       matrix operands to the core (registered)
//   active_send, done_send   send handshake with the core
//   active_single/sa3/sa2    engine selects, one-hot or all zero
//   done_single/sa3/sa2      engine completion flags
//   c11, c12, c21, c22       engine results
//   out_valid/out_data/out_ready result byte stream (c11, c12, c21, c22)
//   busy                     high outside IDLE
//   err_opcode, err_timeout  single-cycle error pulses
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] a11, a12, a13, a14,
  output logic [7:0] a21, a22, a23, a24,
  output logic [7:0] a31, a32, a33, a34,
  output logic [7:0] a41, a42, a43, a44,
  output logic [7:0] b11, b12, b13,
  output logic [7:0] b21, b22, b23,
  output logic [7:0] b31, b32, b33,
  output logic       active_send,
  output logic       active_single,
  output logic       active_sa3,
  output logic       active_sa2,
  input  logic       done_send,
  input  logic       done_single,
  input  logic       done_sa3,
  input  logic       done_sa2,
  input  logic [7:0] c11, c12, c21, c22,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       err_opcode,
  output logic       err_timeout
);

  // Last RUN cycle count value before the wait is abandoned.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state_r;
  mode_t             mode_r;
  logic [3:0]        idx_r;
  logic [1:0]        k_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [7:0]        a_r   [NUM_A];
  logic [7:0]        b_r   [NUM_B];
  logic [7:0]        res_r [NUM_C];
  logic              active_send_r;
  logic              active_single_r;
  logic              active_sa3_r;
  logic              active_sa2_r;
  logic [7:0]        out_data_r;
  logic              busy_r;
  logic              err_opcode_r;
  logic              err_timeout_r;
  logic              accept_s;
  logic              done_sel_s;

  // Flow-control strobes decode the state register only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      ST_IDLE:   in_ready  = 1'b1;
      ST_LOAD_A: in_ready  = 1'b1;
      ST_LOAD_B: in_ready  = 1'b1;
      ST_DRAIN:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Byte accept and the done flag of the engine that was actually selected;
  // flags from other engines are deliberately ignored.
  always_comb begin
    accept_s = in_valid & in_ready;
    case (mode_r)
      MODE_SINGLE: done_sel_s = done_single;
      MODE_SA3:    done_sel_s = done_sa3;
      MODE_SA2:    done_sel_s = done_sa2;
      default:     done_sel_s = 1'b0;
    endcase
  end

  // Sequencer FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      mode_r          <= MODE_SINGLE;
      idx_r           <= 4'd0;
      k_r             <= 2'd0;
      to_cnt_r        <= '0;
      active_send_r   <= 1'b0;
      active_single_r <= 1'b0;
      active_sa3_r    <= 1'b0;
      active_sa2_r    <= 1'b0;
      out_data_r      <= 8'd0;
      busy_r          <= 1'b0;
      err_opcode_r    <= 1'b0;
      err_timeout_r   <= 1'b0;
      for (int i = 0; i < NUM_A; i++) a_r[i] <= 8'd0;
      for (int i = 0; i < NUM_B; i++) b_r[i] <= 8'd0;
      for (int i = 0; i < NUM_C; i++) res_r[i] <= 8'd0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      err_opcode_r  <= 1'b0;
      err_timeout_r <= 1'b0;
      active_send_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (op_legal(in_data)) begin
              mode_r  <= op_to_mode(in_data);
              idx_r   <= 4'd0;
              busy_r  <= 1'b1;
              state_r <= ST_LOAD_A;
            end else begin
              err_opcode_r <= 1'b1;
            end
          end
        end
        ST_LOAD_A: begin
          if (accept_s) begin
            a_r[idx_r] <= in_data;
            if (idx_r == 4'd15) begin
              idx_r   <= 4'd0;
              state_r <= ST_LOAD_B;
            end else begin
              idx_r <= idx_r + 4'd1;
            end
          end
        end
        ST_LOAD_B: begin
          if (accept_s) begin
            b_r[idx_r] <= in_data;
            if (idx_r == 4'd8) begin
              idx_r         <= 4'd0;
              active_send_r <= 1'b1;  // high for the single SEND cycle
              state_r       <= ST_SEND;
            end else begin
              idx_r <= idx_r + 4'd1;
            end
          end
        end
        ST_SEND: begin
          state_r <= ST_WAIT_S;
        end
        ST_WAIT_S: begin
          if (done_send) begin
            to_cnt_r <= '0;
            state_r  <= ST_RUN;
            case (mode_r)
              MODE_SINGLE: active_single_r <= 1'b1;
              MODE_SA3:    active_sa3_r    <= 1'b1;
              MODE_SA2:    active_sa2_r    <= 1'b1;
              default: begin
                busy_r  <= 1'b0;
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
        ST_RUN: begin
          // Done is checked first so it wins over a simultaneous timeout.
          if (done_sel_s) begin
            res_r[0]        <= c11;
            res_r[1]        <= c12;
            res_r[2]        <= c21;
            res_r[3]        <= c22;
            out_data_r      <= c11;
            k_r             <= 2'd0;
            active_single_r <= 1'b0;
            active_sa3_r    <= 1'b0;
            active_sa2_r    <= 1'b0;
            state_r         <= ST_DRAIN;
          end else if (to_cnt_r == TO_LAST) begin
            err_timeout_r   <= 1'b1;
            active_single_r <= 1'b0;
            active_sa3_r    <= 1'b0;
            active_sa2_r    <= 1'b0;
            busy_r          <= 1'b0;
            state_r         <= ST_IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DRAIN: begin
          // out_data only moves on a transfer, so stalls hold it stable.
          if (out_ready) begin
            if (k_r == 2'd3) begin
              out_data_r <= 8'd0;
              busy_r     <= 1'b0;
              state_r    <= ST_IDLE;
            end else begin
              out_data_r <= res_r[k_r + 2'd1];
              k_r        <= k_r + 2'd1;
            end
          end
        end
        default: begin
          active_single_r <= 1'b0;
          active_sa3_r    <= 1'b0;
          active_sa2_r    <= 1'b0;
          busy_r          <= 1'b0;
          state_r         <= ST_IDLE;
        end
      endcase
    end
  end

  // Register array fan-out to the named matrix ports.
  assign a11 = a_r[0];  assign a12 = a_r[1];  assign a13 = a_r[2];  assign a14 = a_r[3];
  assign a21 = a_r[4];  assign a22 = a_r[5];  assign a23 = a_r[6];  assign a24 = a_r[7];
  assign a31 = a_r[8];  assign a32 = a_r[9];  assign a33 = a_r[10]; assign a34 = a_r[11];
  assign a41 = a_r[12]; assign a42 = a_r[13]; assign a43 = a_r[14]; assign a44 = a_r[15];
  assign b11 = b_r[0];  assign b12 = b_r[1];  assign b13 = b_r[2];
  assign b21 = b_r[3];  assign b22 = b_r[4];  assign b23 = b_r[5];
  assign b31 = b_r[6];  assign b32 = b_r[7];  assign b33 = b_r[8];

  assign active_send   = active_send_r;
  assign active_single = active_single_r;
  assign active_sa3    = active_sa3_r;
  assign active_sa2    = active_sa2_r;
  assign out_data      = out_data_r;
  assign busy          = busy_r;
  assign err_opcode    = err_opcode_r;
  assign err_timeout   = err_timeout_r;

endmodule
